// File: rtl/p_fir_engine.sv
// p_fir_engine: streams a BRAM block through a TAPS-deep MAC pipeline
// (read, delay line, multiply-accumulate, round/saturate, write), one sample per clock.
module p_fir_engine #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 5,
   parameter int ADDR_W = 10,
   parameter int SHIFT  = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       src_base,
   input  logic [ADDR_W-1:0]       dst_base,
   input  logic [ADDR_W:0]         len,
   input  logic                    keep_hist,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_idx,
   input  logic [COEF_W-1:0]       coef_data,
   output logic                    rd_en,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [DATA_W-1:0]       rd_data,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    busy,
   output logic                    done
);

   localparam int IDX_W  = $clog2(TAPS);
   localparam int LEN_W  = ADDR_W + 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + IDX_W;
   localparam int RND_W  = ACC_W + 1;

   localparam logic signed [RND_W-1:0] RND_C = RND_W'(1) << (SHIFT - 1);
   localparam logic signed [RND_W-1:0] Y_MAX =
      {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RND_W-1:0] Y_MIN =
      {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [LEN_W-1:0]  rcnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic              v1;
   logic              v2;
   logic              v3;
   logic              accept;
   logic              coef_ok;

   logic signed [DATA_W-1:0] x [TAPS];
   logic signed [COEF_W-1:0] c [TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  mac;
   logic signed [PROD_W-1:0] prod;
   logic signed [RND_W-1:0]  rnd;
   logic signed [RND_W-1:0]  shf;
   logic [DATA_W-1:0]        y;

   assign accept  = (state_q == S_IDLE) && start;
   assign coef_ok = (state_q == S_IDLE) && coef_we
                    && (int'(coef_idx) < TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN ends on the write issued with nothing left behind it
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (len == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (rcnt == LEN_W'(1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (wr_en && !(v1 || v2 || v3)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt    <= '0;
         rd_addr <= '0;
         wr_ptr  <= '0;
      end else begin
         if (accept) begin
            rcnt    <= len;
            rd_addr <= src_base;
         end else if (rd_en) begin
            rcnt    <= rcnt - LEN_W'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
         end
         if (accept) begin
            wr_ptr <= dst_base;
         end else if (v3) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            c[k] <= '0;
         end
      end else if (coef_ok) begin
         c[coef_idx] <= coef_data;
      end
   end

   always_comb begin
      mac  = '0;
      prod = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod = PROD_W'(x[k]) * PROD_W'(c[k]);
         mac  = mac + {{IDX_W{prod[PROD_W-1]}}, prod};
      end
   end

   // one guard bit so the rounding offset cannot wrap the accumulator
   always_comb begin
      rnd = {acc[ACC_W-1], acc} + RND_C;
      shf = rnd >>> SHIFT;
      y   = shf[DATA_W-1:0];
      unique case (1'b1)
         (shf > Y_MAX): y = Y_MAX[DATA_W-1:0];
         (shf < Y_MIN): y = Y_MIN[DATA_W-1:0];
         default:       y = shf[DATA_W-1:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         acc     <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
         end
      end else begin
         v1    <= rd_en;
         v2    <= v1;
         v3    <= v2;
         wr_en <= v3;
         if (accept && !keep_hist) begin
            for (int k = 0; k < TAPS; k++) begin
               x[k] <= '0;
            end
         end else if (v1) begin
            x[0] <= rd_data;
            for (int k = 1; k < TAPS; k++) begin
               x[k] <= x[k-1];
            end
         end
         if (v2) begin
            acc <= mac;
         end
         if (v3) begin
            wr_addr <= wr_ptr;
            wr_data <= y;
         end
      end
   end

endmodule

// File: tb/tb_p_fir_engine.sv
// tb_p_fir_engine: directed and random block runs checked every cycle
// against an expectation schedule built from the FIR equations.
module tb_p_fir_engine;

   localparam int DW = 16;
   localparam int CW = 16;
   localparam int T  = 5;
   localparam int AW = 10;
   localparam int SH = 15;
   localparam int IW = $clog2(T);
   localparam int LW = AW + 1;
   localparam int MSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src_base = '0;
   logic [AW-1:0] dst_base = '0;
   logic [LW-1:0] len = '0;
   logic          keep_hist = 1'b0;
   logic          coef_we = 1'b0;
   logic [IW-1:0] coef_idx = '0;
   logic [CW-1:0] coef_data = '0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;

   p_fir_engine #(
      .DATA_W(DW), .COEF_W(CW), .TAPS(T), .ADDR_W(AW), .SHIFT(SH)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_base(src_base), .dst_base(dst_base), .len(len),
      .keep_hist(keep_hist), .coef_we(coef_we),
      .coef_idx(coef_idx), .coef_data(coef_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [MSZ];
   always @(posedge clk) begin
      rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   int cm [T];
   int mh [T];
   int e_rd [int];
   int e_wa [int];
   int e_wd [int];
   bit e_done [int];
   bit e_busy [int];

   int total = 0;
   int bad = 0;
   int imp_exp [6] = '{16384, 8192, 4096, 2048, 1024, 0};

   function automatic void chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endfunction

   function automatic int fir_out(longint a);
      longint r;
      longint ymax;
      ymax = (longint'(1) << (DW - 1)) - 1;
      r = (a + (longint'(1) << (SH - 1))) >>> SH;
      if (r > ymax) return int'(ymax);
      if (r < -ymax - 1) return int'(-ymax - 1);
      return int'(r);
   endfunction

   // expected schedule for a start presented in cycle s
   function automatic void model_start(int s, int src, int dst,
                                       int n, bit keep);
      longint a;
      if (e_busy.exists(s)) return;
      if (!keep) foreach (mh[k]) mh[k] = 0;
      for (int i = 0; i < n; i++) begin
         for (int k = T - 1; k > 0; k--) mh[k] = mh[k-1];
         mh[0] = $signed(mem[(src + i) % MSZ]);
         a = 0;
         for (int k = 0; k < T; k++) a += longint'(mh[k]) * cm[k];
         e_rd[s + 1 + i] = (src + i) % MSZ;
         e_wa[s + 5 + i] = (dst + i) % MSZ;
         e_wd[s + 5 + i] = fir_out(a);
      end
      if (n == 0) begin
         e_busy[s + 1] = 1'b1;
         e_done[s + 1] = 1'b1;
      end else begin
         for (int t = s + 1; t <= s + n + 5; t++) e_busy[t] = 1'b1;
         e_done[s + n + 5] = 1'b1;
      end
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ctl", {rd_en, wr_en, busy, done}, 0);
         chk("rst_dat", {rd_addr, wr_addr, wr_data}, 0);
      end else begin
         chk("rd_en", rd_en, e_rd.exists(cyc));
         if (rd_en && e_rd.exists(cyc))
            chk("rd_addr", rd_addr, e_rd[cyc]);
         chk("wr_en", wr_en, e_wa.exists(cyc));
         if (wr_en && e_wa.exists(cyc)) begin
            chk("wr_addr", wr_addr, e_wa[cyc]);
            chk("wr_data", $signed(wr_data), e_wd[cyc]);
         end
         chk("done", done, e_done.exists(cyc));
         chk("busy", busy, e_busy.exists(cyc));
      end
   end

   task automatic wcoef(input int idx, input int val);
      @(negedge clk); #1;
      coef_we = 1'b1;
      coef_idx = IW'(idx);
      coef_data = CW'(val);
      if (!e_busy.exists(cyc) && idx < T) cm[idx] = val;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic run(output int s, input int src, input int dst,
                      input int n, input bit keep, input bit cw = 1'b0,
                      input int ci = 0, input int cv = 0);
      @(negedge clk); #1;
      s = cyc;
      start = 1'b1;
      src_base = AW'(src);
      dst_base = AW'(dst);
      len = LW'(n);
      keep_hist = keep;
      if (cw) begin
         coef_we = 1'b1;
         coef_idx = IW'(ci);
         coef_data = CW'(cv);
         if (!e_busy.exists(cyc) && ci < T) cm[ci] = cv;
      end
      model_start(s, src, dst, n, keep);
      @(posedge clk); #1;
      start = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic wait_done(output int frd, output int fwr, output int dn);
      frd = -1;
      fwr = -1;
      dn = -1;
      for (int k = 0; k < 3000 && dn < 0; k++) begin
         @(negedge clk);
         if (rd_en && frd < 0) frd = cyc;
         if (wr_en && fwr < 0) fwr = cyc;
         if (done) dn = cyc;
      end
      if (dn < 0) chk("done_timeout", 0, 1);
   endtask

   int s, s2, frd, fwr, dn;
   int src, dst, n;

   initial begin
      foreach (mem[i]) mem[i] = DW'($urandom);
      foreach (cm[k]) cm[k] = 0;
      foreach (mh[k]) mh[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state",
          {rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}, 0);
      rst = 1'b0;

      chk("model_half", fir_out(longint'(32767) * 16384), 16384);
      chk("model_rnd", fir_out(16384), 1);
      chk("model_satp", fir_out(longint'(5) * 32767 * 32767), 32767);
      chk("model_satn", fir_out(-longint'(5) * 32768 * 32767), -32768);

      wcoef(0, 16384);
      wcoef(1, 8192);
      wcoef(2, 4096);
      wcoef(3, 2048);
      wcoef(4, 1024);
      mem[0] = 16'h7fff;
      for (int i = 1; i < 6; i++) mem[i] = '0;
      run(s, 0, 512, 6, 1'b0);
      wait_done(frd, fwr, dn);
      chk("imp_latency", fwr - frd, 4);
      chk("imp_done_at", dn - s, 11);
      for (int j = 0; j < 6; j++)
         chk("imp_out", $signed(mem[512 + j]), imp_exp[j]);

      for (int k = 0; k < T; k++) wcoef(k, 32767);
      for (int i = 0; i < 5; i++) mem[16 + i] = 16'h7fff;
      run(s, 16, 520, 5, 1'b0);
      wait_done(frd, fwr, dn);
      chk("sat_pos", $signed(mem[524]), 32767);
      for (int i = 0; i < 5; i++) mem[32 + i] = 16'h8000;
      run(s, 32, 530, 5, 1'b0);
      wait_done(frd, fwr, dn);
      chk("sat_neg", $signed(mem[534]), -32768);

      wcoef(0, 16384);
      for (int k = 1; k < T; k++) wcoef(k, 0);
      mem[48] = 16'd1;
      run(s, 48, 540, 1, 1'b0);
      wait_done(frd, fwr, dn);
      chk("round_half", $signed(mem[540]), 1);

      wcoef(0, 20000);
      wcoef(1, 15000);
      wcoef(2, 12000);
      wcoef(3, 9000);
      wcoef(4, 16000);
      for (int i = 0; i < 20; i++) mem[64 + i] = DW'(i + 1);
      run(s, 64, 600, 10, 1'b0);
      wait_done(frd, fwr, dn);
      run(s, 74, 610, 10, 1'b1);
      wait_done(frd, fwr, dn);
      run(s, 74, 700, 10, 1'b0);
      wait_done(frd, fwr, dn);
      run(s, 64, 800, 20, 1'b0);
      wait_done(frd, fwr, dn);
      for (int j = 0; j < 20; j++)
         chk("cont_match", mem[600 + j], mem[800 + j]);
      for (int j = 0; j < 4; j++)
         chk("hist_diff", mem[610 + j] != mem[700 + j], 1);
      for (int j = 4; j < 10; j++)
         chk("hist_same", mem[610 + j], mem[700 + j]);

      run(s, 100, 900, 0, 1'b0);
      wait_done(frd, fwr, dn);
      chk("len0_done_at", dn - s, 1);
      chk("len0_no_rd", frd, -1);
      chk("len0_no_wr", fwr, -1);

      run(s, 64, 850, 12, 1'b0);
      repeat (3) @(posedge clk);
      run(s2, 0, 0, 5, 1'b1);
      wcoef(0, 1234);
      wcoef(3, -777);
      wait_done(frd, fwr, dn);
      chk("busy_start_done_at", dn - s, 17);
      run(s, 64, 870, 8, 1'b0);
      wait_done(frd, fwr, dn);

      wcoef(5, 777);
      wcoef(7, -5);
      run(s, 64, 880, 8, 1'b0, 1'b1, 1, -7000);
      wait_done(frd, fwr, dn);

      for (int i = 0; i < 4; i++) mem[(1022 + i) % MSZ] = DW'(1000 * (i + 1));
      run(s, 1022, 1020, 4, 1'b0);
      wait_done(frd, fwr, dn);
      chk("wrap_done_at", dn - s, 9);

      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < T; k++)
            wcoef(k, int'($urandom_range(0, 65535)) - 32768);
         src = $urandom_range(0, 300);
         n = $urandom_range(1, 40);
         dst = (src + 500 + $urandom_range(0, 100)) % MSZ;
         run(s, src, dst, n, 1'($urandom_range(0, 1)));
         wait_done(frd, fwr, dn);
         chk("rand_done_at", dn - s, n + 5);
      end

      for (int k = 0; k < T; k++) wcoef(k, 3000 * (k + 1));
      run(s, 64, 600, 20, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      e_rd.delete();
      e_wa.delete();
      e_wd.delete();
      e_done.delete();
      e_busy.delete();
      foreach (cm[k]) cm[k] = 0;
      foreach (mh[k]) mh[k] = 0;
      #1;
      chk("rst_abort",
          {rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) mem[900 + i] = 16'h1234;
      run(s, 64, 900, 8, 1'b1);
      wait_done(frd, fwr, dn);
      for (int j = 0; j < 8; j++)
         chk("post_rst_zero", mem[900 + j], 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
